// File: rtl/flappy_pkg.sv
// Shared encodings for the flappy game controller and the VGA score overlay.
package flappy_pkg;

    localparam int SCORE_W = 10;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;

    localparam logic [5:0] S_IDLE     = 6'b000001;
    localparam logic [5:0] S_ARMING   = 6'b000010;
    localparam logic [5:0] S_RUN      = 6'b000100;
    localparam logic [5:0] S_STOPPING = 6'b001000;
    localparam logic [5:0] S_DEAD     = 6'b010000;
    localparam logic [5:0] S_ACKING   = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE     = S_IDLE,
        ST_ARMING   = S_ARMING,
        ST_RUN      = S_RUN,
        ST_STOPPING = S_STOPPING,
        ST_DEAD     = S_DEAD,
        ST_ACKING   = S_ACKING
    } state_e;

endpackage

// File: rtl/scroll_tick_gen.sv
// Reload counter producing a one-cycle scroll step every 'period' clocks.
module scroll_tick_gen #(
    parameter int RESET_PERIOD = 200000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [19:0] period,
    output logic        tick
);

    logic [19:0] cnt_q;
    logic [19:0] per_q;

    assign tick = (cnt_q == per_q - 20'd1);

    // The period only changes at reload so a running step interval is never cut short.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            per_q <= 20'(RESET_PERIOD);
        end else if (tick) begin
            cnt_q <= '0;
            per_q <= period;
        end else begin
            cnt_q <= cnt_q + 20'd1;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-flow FSM: drives the scroller handshake, scroll speed, score and level.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int TICK_DIV_BASE   = 200000,
    parameter int DIV_STEP        = 25000,
    parameter int MAX_LEVEL       = 4,
    parameter int PIPES_PER_LEVEL = 5,
    parameter int DEAD_HOLD       = 60,
    parameter int HS_TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               btn,
    input  logic               collide,
    input  logic               pipe_passed,
    input  logic               x_q_initial,
    input  logic               x_q_count,
    input  logic               x_q_stop,
    output logic               x_start,
    output logic               x_stop,
    output logic               x_ack,
    output logic               scroll_en,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         level,
    output logic               q_idle,
    output logic               q_arming,
    output logic               q_run,
    output logic               q_stopping,
    output logic               q_dead,
    output logic               q_acking,
    output logic               hs_err
);

    localparam int SUB_W  = $clog2(PIPES_PER_LEVEL + 1);
    localparam int HOLD_W = $clog2(DEAD_HOLD + 1);
    localparam int TO_W   = $clog2(HS_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         level_q, level_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic               hs_err_q, hs_err_d;
    logic               btn_q;
    logic               btn_rise;
    logic               hs_state;
    logic [19:0]        period;

    assign btn_rise = btn & ~btn_q;
    assign period   = 20'(TICK_DIV_BASE) - 20'(level_q) * 20'(DIV_STEP);

    scroll_tick_gen #(.RESET_PERIOD(TICK_DIV_BASE)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period),
        .tick    (scroll_en)
    );

    assign hs_state = (state_q == ST_ARMING) || (state_q == ST_STOPPING) ||
                      (state_q == ST_ACKING);

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        level_d  = level_q;
        sub_d    = sub_q;
        hold_d   = hold_q;
        to_d     = to_q;
        hs_err_d = hs_err_q;
        case (state_q)
            ST_IDLE:   if (btn_rise) state_d = ST_ARMING;
            ST_ARMING: if (x_q_count) state_d = ST_RUN;
            ST_RUN: begin
                // A pass in the collision cycle still counts.
                if (pipe_passed) begin
                    if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
                    if (sub_q == SUB_W'(PIPES_PER_LEVEL - 1)) begin
                        sub_d = '0;
                        if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                if (collide) state_d = ST_STOPPING;
            end
            ST_STOPPING: if (x_q_stop) begin
                state_d = ST_DEAD;
                hold_d  = '0;
            end
            ST_DEAD: begin
                if (scroll_en && hold_q != HOLD_W'(DEAD_HOLD)) hold_d = hold_q + 1'b1;
                if (btn_rise && hold_q == HOLD_W'(DEAD_HOLD)) state_d = ST_ACKING;
            end
            ST_ACKING: if (x_q_initial) begin
                state_d = ST_IDLE;
                score_d = '0;
                level_d = '0;
                sub_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout watches the scroller's progress in steps, restarting on every state change.
        if (state_d != state_q)
            to_d = '0;
        else if (hs_state && scroll_en && to_q != TO_W'(HS_TIMEOUT))
            to_d = to_q + 1'b1;
        if (hs_state && to_q == TO_W'(HS_TIMEOUT)) hs_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            score_q  <= '0;
            level_q  <= '0;
            sub_q    <= '0;
            hold_q   <= '0;
            to_q     <= '0;
            hs_err_q <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            level_q  <= level_d;
            sub_q    <= sub_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            hs_err_q <= hs_err_d;
            btn_q    <= btn;
        end
    end

    assign q_idle     = (state_q == ST_IDLE);
    assign q_arming   = (state_q == ST_ARMING);
    assign q_run      = (state_q == ST_RUN);
    assign q_stopping = (state_q == ST_STOPPING);
    assign q_dead     = (state_q == ST_DEAD);
    assign q_acking   = (state_q == ST_ACKING);

    // Requests decode straight from the state register, so they are glitch-free Moore outputs.
    assign x_start = q_arming;
    assign x_stop  = q_stopping;
    assign x_ack   = q_acking;
    assign score   = score_q;
    assign level   = level_q;
    assign hs_err  = hs_err_q;

endmodule
